// File: rtl/decode_issue.sv
// decode_issue: single-stage decode and issue with an 8-entry register file
// and a busy-bit scoreboard.
//
// Optional feature: define DECODE_BYPASS_EN to forward a same-cycle writeback
// into the operand read and clear the matching source hazard. Without it, a
// source waiting on a writeback stalls one cycle and then reads the register
// file.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   instr, instr_valid  instruction in; accepted when valid and instr_ready
//   instr_ready         no hazard and stage not held by a downstream stall
//   alu_stall           downstream cannot take a new op
//   wb_en, wb_addr,
//   wb_data             register writeback (clears the busy bit)
//   alu_en              issued op valid
//   in1, reg_in2,
//   imm_in2             operands (rs1, rs2, sign-extended imm5)
//   funct, ALUSrc       ALU function, 1 selects imm_in2
//   issue_rd            destination tag
module decode_issue #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_REGS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          instr,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic                 alu_stall,
   input  logic                 wb_en,
   input  logic [2:0]           wb_addr,
   input  logic [WORD_SIZE-1:0] wb_data,
   output logic                 alu_en,
   output logic [WORD_SIZE-1:0] in1,
   output logic [WORD_SIZE-1:0] reg_in2,
   output logic [WORD_SIZE-1:0] imm_in2,
   output logic [3:0]           funct,
   output logic                 ALUSrc,
   output logic [2:0]           issue_rd
);

   localparam logic [3:0] NOP_FUNCT = 4'b0111;

   logic [3:0]           op;
   logic [2:0]           rd_f, rs1_f, rs2_f;
   logic                 src_f;
   logic [4:0]           imm5;
   logic                 writes;

   logic [WORD_SIZE-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]  busy;
   logic [NUM_REGS-1:0]  set_mask, clr_mask;

   logic [WORD_SIZE-1:0] rs1_val, rs2_val;
   logic                 rs1_blk, rs2_blk;
   logic                 hazard, held, accept;

   assign op     = instr[15:12];
   assign rd_f   = instr[11:9];
   assign rs1_f  = instr[8:6];
   assign src_f  = instr[5];
   assign imm5   = instr[4:0];
   assign rs2_f  = instr[2:0];
   assign writes = (op != NOP_FUNCT);

   // r0 is never written and resets to zero, so a plain read returns 0;
   // busy[0] is likewise never set.
   always_comb begin
      rs1_val = regs[rs1_f];
      rs2_val = regs[rs2_f];
      rs1_blk = busy[rs1_f];
      rs2_blk = busy[rs2_f];
`ifdef DECODE_BYPASS_EN
      if (wb_en && (wb_addr == rs1_f) && (rs1_f != 3'd0)) begin
         rs1_val = wb_data;
         rs1_blk = 1'b0;
      end
      if (wb_en && (wb_addr == rs2_f) && (rs2_f != 3'd0)) begin
         rs2_val = wb_data;
         rs2_blk = 1'b0;
      end
`endif
   end

   assign hazard      = rs1_blk | (~src_f & rs2_blk) | (writes & busy[rd_f]);
   assign held        = alu_en & alu_stall;
   assign instr_ready = ~hazard & ~held;
   assign accept      = instr_valid & instr_ready;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (accept && writes && (rd_f != 3'd0))
         set_mask[rd_f] = 1'b1;
      if (wb_en)
         clr_mask[wb_addr] = 1'b1;
   end

   // Set is applied after clear so a same-bit collision leaves the bit set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         busy <= '0;
      else
         busy <= (busy & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wb_en && (wb_addr != 3'd0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_en   <= 1'b0;
         in1      <= '0;
         reg_in2  <= '0;
         imm_in2  <= '0;
         funct    <= NOP_FUNCT;
         ALUSrc   <= 1'b0;
         issue_rd <= '0;
      end else if (accept) begin
         alu_en   <= 1'b1;
         in1      <= rs1_val;
         reg_in2  <= rs2_val;
         imm_in2  <= {{(WORD_SIZE-5){imm5[4]}}, imm5};
         funct    <= op;
         ALUSrc   <= src_f;
         issue_rd <= rd_f;
      end else if (!held) begin
         alu_en   <= 1'b0;
      end
   end

endmodule
